boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- N, 32, file word width.
- AW, 32, memory address width.
- BASE_ADDR, 32'h0, first load address.
- MAX_WORDS, 4096, load size limit in words.
- MAX_RETRIES, 3, number of retries after err or timeout.
- TIMEOUT, 2**20, max cycles to wait for one word.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- boot_req  in  1  one-cycle pulse that starts a load.
- fs_rst  out  1  active-high reset to the filesystem wrapper.
- fs_start  out  1  start pulse to the filesystem wrapper.
- fs_next_data  out  1  next-word request pulse.
- fs_busy  in  1  wrapper busy.
- fs_data  in  N  wrapper word.
- fs_eof  in  1  end of file.
- fs_not_found  in  1  file missing.
- fs_err  in  1  SD/filesystem error.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  word address.
- mem_wdata  out  N  write data.
- mem_ready  in  1  write accepted.
- cpu_rst_n  out  1  CPU held in reset while low.
- busy  out  1  load in progress.
- done  out  1  load succeeded (sticky).
- fail  out  1  load failed (sticky).
- fail_code  out  2  0 not_found, 1 err/timeout after retries, 2 overflow.
- words_loaded  out  AW  count of words written.

Function
REQ-003 SHALL implement states IDLE, FS_RST, START, ARM, WAIT, WRITE, NEXT, DONE, FAIL.
REQ-004 IDLE: boot_req moves to FS_RST, clears done/fail/words_loaded and sets the address to BASE_ADDR; boot_req SHALL be ignored in all other states.
REQ-005 FS_RST SHALL assert fs_rst for exactly 2 cycles, then go to START.
REQ-006 START SHALL assert fs_start for 1 cycle, then go to ARM.
REQ-007 ARM SHALL last 1 cycle with no sampling, then go to WAIT; this absorbs the wrapper's busy-rise latency.
REQ-008 WAIT SHALL sample the wrapper each cycle while fs_busy=1 and increment the timeout counter; when fs_busy=0 it SHALL decide, in this priority:
- fs_not_found → FAIL with code 0.
- fs_err → retry.
- fs_eof → DONE, with no write.
- words_loaded==MAX_WORDS → FAIL with code 2.
- else → WRITE, latching fs_data into mem_wdata.
REQ-009 The timeout counter reaching TIMEOUT-1 in WAIT SHALL trigger a retry.
REQ-010 Retry: if the retry count < MAX_RETRIES, increment it and go to FS_RST, restarting the load from BASE_ADDR with words_loaded=0; otherwise go to FAIL with code 1.
REQ-011 WRITE SHALL hold mem_we=1 with stable mem_addr/mem_wdata until mem_ready=1; on that cycle it SHALL increment words_loaded and the address (+1) and go to NEXT.
REQ-012 NEXT SHALL assert fs_next_data for 1 cycle, clear the timeout counter, then go to ARM.
REQ-013 DONE SHALL set done=1 and cpu_rst_n=1 and remain there until reset.
REQ-014 FAIL SHALL set fail=1 and fail_code, keep cpu_rst_n=0, and return to IDLE on boot_req.
REQ-015 busy SHALL be 1 in every state except IDLE, DONE and FAIL.
REQ-016 done and fail SHALL never be 1 simultaneously.
REQ-017 The timeout counter SHALL be cleared on entry to ARM from START or NEXT.
REQ-018 The retry count SHALL be cleared only by boot_req in IDLE.
REQ-019 fs_start, fs_next_data and fs_rst SHALL each be 1-cycle or fixed-length pulses and never overlap.
REQ-020 mem_addr SHALL wrap modulo 2^AW; the wrap is not flagged.

Reset
REQ-021 rst=0 SHALL asynchronously force:
- state IDLE;
- fs_rst=1 while rst is low, 0 after release;
- all other outputs 0, including cpu_rst_n=0, mem_we=0, words_loaded=0;
- retry and timeout counters 0.
REQ-022 Reset asserted mid-load SHALL abort immediately; no partial mem_we pulse SHALL follow reset release.

Verification
REQ-023 Nominal: 3-word file 0xA,0xB,0xC then eof, mem_ready always 1 → writes at BASE,+1,+2, words_loaded=3, done=1, cpu_rst_n=1.
REQ-024 Backpressure: mem_ready low for 5 cycles on word 2 → mem_we held 6 cycles, address and data stable, only one increment.
REQ-025 Not found: fs_not_found with fs_busy=0 after start → fail=1, fail_code=0, no fs_rst retry pulse.
REQ-026 Error retries: fs_err on every attempt with MAX_RETRIES=3 → 4 fs_start pulses, then fail_code=1; an err on attempt 2 followed by success → done=1, words_loaded restarted from 0.
REQ-027 Timeout and overflow: fs_busy stuck high, TIMEOUT=16 → retry after 16 WAIT cycles; a file with MAX_WORDS+1 words → fail_code=2, words_loaded=MAX_WORDS.
REQ-028 Reset during WRITE with mem_ready=0 → mem_we=0 at once; all outputs at reset values; a new boot_req works normally.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : boot_loader_ctrl
//  Purpose  : Streams a boot image from a filesystem wrapper into memory,
//             one word at a time, with retry/timeout handling, then releases
//             the CPU from reset on success.
//  Revision : 1.0 - initial release
// ============================================================================
module boot_loader_ctrl #(
  parameter int             N           = 32,
  parameter int             AW          = 32,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             MAX_WORDS   = 4096,
  parameter int             MAX_RETRIES = 3,
  parameter int             TIMEOUT     = 2**20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_req,
  output logic          fs_rst,
  output logic          fs_start,
  output logic          fs_next_data,
  input  logic          fs_busy,
  input  logic [N-1:0]  fs_data,
  input  logic          fs_eof,
  input  logic          fs_not_found,
  input  logic          fs_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic          mem_ready,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic [AW-1:0] words_loaded
);

  // Counter widths sized so the largest value they must hold fits.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] c_RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [AW-1:0] c_MAX_WORDS = AW'(MAX_WORDS);

  localparam logic [1:0] c_CODE_NOT_FOUND = 2'd0;
  localparam logic [1:0] c_CODE_ERR       = 2'd1;
  localparam logic [1:0] c_CODE_OVERFLOW  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FS_RST = 4'd1,
    S_START  = 4'd2,
    S_ARM    = 4'd3,
    S_WAIT   = 4'd4,
    S_WRITE  = 4'd5,
    S_NEXT   = 4'd6,
    S_DONE   = 4'd7,
    S_FAIL   = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic          fsr_cnt_q, fsr_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [AW-1:0] words_q, words_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [1:0]    code_q, code_d;
  logic          w_retry;

  // State and datapath registers; reset aborts any load in progress at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      fsr_cnt_q <= 1'b0;
      to_cnt_q  <= '0;
      retry_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      words_q   <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      fsr_cnt_q <= fsr_cnt_d;
      to_cnt_q  <= to_cnt_d;
      retry_q   <= retry_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      words_q   <= words_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      code_q    <= code_d;
    end
  end

  // Next-state logic: sequencing, wrapper decision priority and retry policy.
  always_comb begin
    state_d   = state_q;
    fsr_cnt_d = fsr_cnt_q;
    to_cnt_d  = to_cnt_q;
    retry_d   = retry_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    words_d   = words_q;
    done_d    = done_q;
    fail_d    = fail_q;
    code_d    = code_q;
    w_retry   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (boot_req) begin
          state_d   = S_FS_RST;
          done_d    = 1'b0;
          fail_d    = 1'b0;
          words_d   = '0;
          addr_d    = BASE_ADDR;
          retry_d   = '0;
          fsr_cnt_d = 1'b0;
          to_cnt_d  = '0;
        end
      end

      // Two-cycle wrapper reset: second cycle moves on.
      S_FS_RST: begin
        if (fsr_cnt_q) begin
          fsr_cnt_d = 1'b0;
          state_d   = S_START;
        end else begin
          fsr_cnt_d = 1'b1;
        end
      end

      S_START: begin
        to_cnt_d = '0;
        state_d  = S_ARM;
      end

      // Wrapper busy may not yet be visible here, so nothing is sampled.
      S_ARM: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (fs_busy) begin
          if (to_cnt_q == c_TO_LAST) begin
            w_retry = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else if (fs_not_found) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          code_d  = c_CODE_NOT_FOUND;
        end else if (fs_err) begin
          w_retry = 1'b1;
        end else if (fs_eof) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (words_q == c_MAX_WORDS) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          code_d  = c_CODE_OVERFLOW;
        end else begin
          state_d = S_WRITE;
          wdata_d = fs_data;
        end

        // A retry restarts the whole file from the first load address.
        if (w_retry) begin
          if (retry_q < c_RETRY_MAX) begin
            retry_d   = retry_q + 1'b1;
            state_d   = S_FS_RST;
            fsr_cnt_d = 1'b0;
            words_d   = '0;
            addr_d    = BASE_ADDR;
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            code_d  = c_CODE_ERR;
          end
        end
      end

      // Address and data are held until memory accepts the word.
      S_WRITE: begin
        if (mem_ready) begin
          words_d = words_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        to_cnt_d = '0;
        state_d  = S_ARM;
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      S_FAIL: begin
        if (boot_req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign fs_rst       = ~rst | (state_q == S_FS_RST);
  assign fs_start     = (state_q == S_START);
  assign fs_next_data = (state_q == S_NEXT);
  assign mem_we       = (state_q == S_WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_rst_n    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign done         = done_q;
  assign fail         = fail_q;
  assign fail_code    = code_q;
  assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_loader_ctrl
//  Purpose  : Directed self-checking bench for boot_loader_ctrl with a small
//             behavioural filesystem wrapper and memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader_ctrl;

  localparam int             N     = 32;
  localparam int             AW    = 16;
  localparam logic [AW-1:0]  BASE  = 16'h0100;
  localparam int             MAXW  = 4;
  localparam int             MAXR  = 3;
  localparam int             TOUT  = 16;
  localparam int             LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          boot_req = 1'b0;
  logic          fs_rst, fs_start, fs_next_data;
  logic          fs_busy = 1'b0;
  logic [N-1:0]  fs_data;
  logic          fs_eof, fs_not_found, fs_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_ready = 1'b1;
  logic          cpu_rst_n, busy, done, fail;
  logic [1:0]    fail_code;
  logic [AW-1:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  // Scenario knobs, written only by the main sequence.
  logic [N-1:0] file_mem [16];
  int  flen = 0;
  int  err_upto = 0;
  int  err_idx = 0;
  int  att_base = 0;
  bit  nf = 1'b0;
  bit  stuck = 1'b0;
  int  stall_idx = -1;
  int  stall_cycles = 0;

  // Responder/monitor state, written only by the responder process.
  int  idx = 0;
  int  attempt = 0;
  int  bcnt = 0;
  int  cyc = 0;
  int  start_cnt = 0;
  int  rst_cyc = 0;
  int  wr_n = 0;
  int  we_total = 0;
  int  t_start = 0;
  int  last_gap = 0;
  bit  in_wr = 1'b0;
  bit  unstable = 1'b0;
  bit  both_seen = 1'b0;
  logic [AW-1:0] log_addr [64];
  logic [N-1:0]  log_data [64];
  int            we_cyc   [64];

  assign fs_data      = (idx < flen) ? file_mem[idx] : '0;
  assign fs_eof       = (idx >= flen);
  assign fs_not_found = nf;
  assign fs_err       = ((attempt - att_base) >= 1) && ((attempt - att_base) <= err_upto) && (idx >= err_idx);

  boot_loader_ctrl #(
    .N(N), .AW(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW),
    .MAX_RETRIES(MAXR), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .boot_req(boot_req),
    .fs_rst(fs_rst), .fs_start(fs_start), .fs_next_data(fs_next_data),
    .fs_busy(fs_busy), .fs_data(fs_data), .fs_eof(fs_eof),
    .fs_not_found(fs_not_found), .fs_err(fs_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .cpu_rst_n(cpu_rst_n), .busy(busy),
    .done(done), .fail(fail), .fail_code(fail_code),
    .words_loaded(words_loaded)
  );

  initial forever #5 clk = ~clk;

  // Wrapper + memory model: reacts on the falling edge, away from the DUT edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (done && fail) both_seen = 1'b1;
      if (fs_start && fs_next_data || fs_start && fs_rst || fs_next_data && fs_rst) both_seen = 1'b1;
      if (!rst) begin
        idx = 0; fs_busy = 1'b0; in_wr = 1'b0; mem_ready = 1'b1;
      end else begin
        if (fs_rst) begin
          rst_cyc = rst_cyc + 1;
          if (last_gap == 0) last_gap = cyc - t_start;
          idx = 0; fs_busy = 1'b0;
        end else if (fs_start) begin
          start_cnt = start_cnt + 1; attempt = attempt + 1;
          t_start = cyc; last_gap = 0;
          fs_busy = 1'b1; bcnt = LAT;
        end else if (fs_next_data) begin
          idx = idx + 1; fs_busy = 1'b1; bcnt = LAT;
        end else if (fs_busy && !stuck) begin
          if (bcnt == 0) fs_busy = 1'b0;
          else bcnt = bcnt - 1;
        end
        if (mem_we && wr_n < 64) begin
          we_total = we_total + 1;
          if (!in_wr) begin
            in_wr = 1'b1; log_addr[wr_n] = mem_addr; log_data[wr_n] = mem_wdata; we_cyc[wr_n] = 0;
          end else if (mem_addr !== log_addr[wr_n] || mem_wdata !== log_data[wr_n]) begin
            unstable = 1'b1;
          end
          we_cyc[wr_n] = we_cyc[wr_n] + 1;
          if (wr_n == stall_idx && we_cyc[wr_n] <= stall_cycles) begin
            mem_ready = 1'b0;
          end else begin
            mem_ready = 1'b1; wr_n = wr_n + 1; in_wr = 1'b0;
          end
        end else begin
          mem_ready = 1'b1; in_wr = 1'b0;
        end
      end
    end
  end

  task automatic load_abc();
    file_mem[0] = 32'hA; file_mem[1] = 32'hB; file_mem[2] = 32'hC; flen = 3;
  endtask

  task automatic clear_knobs();
    nf = 1'b0; stuck = 1'b0; err_upto = 0; err_idx = 0; stall_idx = -1; stall_cycles = 0;
    att_base = attempt;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; boot_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_boot();
    @(negedge clk); boot_req = 1'b1;
    @(negedge clk); boot_req = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    bit expired;
    expired = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      if (done || fail) begin expired = 1'b0; break; end
      @(negedge clk);
    end
    n_checks++;
    if (expired) begin n_errors++; $display("FAIL %s_timeout: no done/fail within %0d cycles", tag, maxc); end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (fs_rst !== 1'b1) begin n_errors++; $display("FAIL reset_fs_rst: got %b want 1", fs_rst); end
    n_checks++; if ({mem_we, cpu_rst_n, busy, done, fail, fs_start, fs_next_data} !== 7'b0) begin
      n_errors++; $display("FAIL reset_outs: got %b want 0000000", {mem_we, cpu_rst_n, busy, done, fail, fs_start, fs_next_data}); end
    n_checks++; if (words_loaded !== '0 || fail_code !== 2'd0 || mem_addr !== '0) begin
      n_errors++; $display("FAIL reset_regs: words %h code %0d addr %h want 0", words_loaded, fail_code, mem_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (fs_rst !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_release: fs_rst %b busy %b want 0 0", fs_rst, busy); end
  endtask

  task automatic test_nominal();
    int s0, r0, w0;
    clear_knobs(); load_abc();
    s0 = start_cnt; r0 = rst_cyc; w0 = wr_n;
    pulse_boot();
    repeat (4) @(negedge clk);
    pulse_boot();
    wait_end("nominal", 300);
    n_checks++; if (done !== 1'b1 || fail !== 1'b0 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL nominal_flags: done %b fail %b cpu_rst_n %b busy %b want 1 0 1 0", done, fail, cpu_rst_n, busy); end
    n_checks++; if (words_loaded !== 16'd3) begin n_errors++; $display("FAIL nominal_words: got %0d want 3", words_loaded); end
    n_checks++; if (wr_n - w0 != 3) begin n_errors++; $display("FAIL nominal_writes: got %0d want 3", wr_n - w0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (log_addr[w0+i] !== BASE + 16'(i) || log_data[w0+i] !== 32'hA + 32'(i)) begin
        n_errors++; $display("FAIL nominal_wr%0d: addr %h data %h want %h %h", i, log_addr[w0+i], log_data[w0+i], BASE + 16'(i), 32'hA + 32'(i)); end
    end
    n_checks++; if (start_cnt - s0 != 1 || rst_cyc - r0 != 2) begin
      n_errors++; $display("FAIL nominal_pulses: starts %0d fs_rst cycles %0d want 1 2", start_cnt - s0, rst_cyc - r0); end
    pulse_boot();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL done_sticky: done %b busy %b want 1 0", done, busy); end
  endtask

  task automatic test_backpressure();
    int w0;
    do_reset(); clear_knobs(); load_abc();
    w0 = wr_n; stall_idx = w0 + 1; stall_cycles = 5; unstable = 1'b0;
    pulse_boot();
    wait_end("bp", 300);
    n_checks++; if (we_cyc[w0+1] != 6) begin n_errors++; $display("FAIL bp_we_cycles: got %0d want 6", we_cyc[w0+1]); end
    n_checks++; if (unstable) begin n_errors++; $display("FAIL bp_stable: addr/data changed while stalled, want stable"); end
    n_checks++; if (words_loaded !== 16'd3 || wr_n - w0 != 3 || done !== 1'b1) begin
      n_errors++; $display("FAIL bp_count: words %0d writes %0d done %b want 3 3 1", words_loaded, wr_n - w0, done); end
    n_checks++; if (log_addr[w0+2] !== BASE + 16'd2) begin n_errors++; $display("FAIL bp_addr3: got %h want %h", log_addr[w0+2], BASE + 16'd2); end
  endtask

  task automatic test_not_found();
    int s0, r0;
    do_reset(); clear_knobs(); load_abc(); nf = 1'b1;
    s0 = start_cnt; r0 = rst_cyc;
    pulse_boot();
    wait_end("nf", 200);
    n_checks++; if (fail !== 1'b1 || fail_code !== 2'd0 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
      n_errors++; $display("FAIL nf_flags: fail %b code %0d done %b cpu %b want 1 0 0 0", fail, fail_code, done, cpu_rst_n); end
    n_checks++; if (rst_cyc - r0 != 2 || start_cnt - s0 != 1) begin
      n_errors++; $display("FAIL nf_no_retry: fs_rst cycles %0d starts %0d want 2 1", rst_cyc - r0, start_cnt - s0); end
    pulse_boot();
    n_checks++; if (busy !== 1'b0 || cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL nf_to_idle: busy %b cpu %b want 0 0", busy, cpu_rst_n); end
    nf = 1'b0;
    pulse_boot();
    wait_end("nf_recover", 300);
    n_checks++; if (done !== 1'b1 || fail !== 1'b0 || words_loaded !== 16'd3) begin
      n_errors++; $display("FAIL nf_recover: done %b fail %b words %0d want 1 0 3", done, fail, words_loaded); end
  endtask

  task automatic test_err_retries();
    int s0, r0, w0;
    do_reset(); clear_knobs(); load_abc(); err_upto = 99;
    s0 = start_cnt; r0 = rst_cyc;
    pulse_boot();
    wait_end("err_all", 400);
    n_checks++; if (start_cnt - s0 != 4 || rst_cyc - r0 != 8) begin
      n_errors++; $display("FAIL err_pulses: starts %0d fs_rst cycles %0d want 4 8", start_cnt - s0, rst_cyc - r0); end
    n_checks++; if (fail !== 1'b1 || fail_code !== 2'd1) begin n_errors++; $display("FAIL err_code: fail %b code %0d want 1 1", fail, fail_code); end
    // First attempt errors after two words; second attempt completes.
    do_reset(); clear_knobs(); load_abc(); err_upto = 1; err_idx = 2;
    s0 = start_cnt; w0 = wr_n;
    pulse_boot();
    wait_end("err_once", 400);
    n_checks++; if (done !== 1'b1 || words_loaded !== 16'd3 || start_cnt - s0 != 2) begin
      n_errors++; $display("FAIL err_recover: done %b words %0d starts %0d want 1 3 2", done, words_loaded, start_cnt - s0); end
    n_checks++; if (wr_n - w0 != 5 || log_addr[w0+2] !== BASE || log_data[w0+2] !== 32'hA) begin
      n_errors++; $display("FAIL err_restart: writes %0d addr %h data %h want 5 %h a", wr_n - w0, log_addr[w0+2], BASE, log_data[w0+2]); end
  endtask

  task automatic test_timeout();
    int s0;
    do_reset(); clear_knobs(); load_abc(); stuck = 1'b1;
    s0 = start_cnt;
    pulse_boot();
    // START + ARM + 16 WAIT cycles before the retry reset appears.
    for (int i = 0; i < 60 && !(rst_cyc > 0 && start_cnt - s0 == 1 && last_gap != 0); i++) @(negedge clk);
    n_checks++; if (last_gap != 18) begin n_errors++; $display("FAIL to_gap: start-to-retry %0d cycles want 18", last_gap); end
    wait_end("timeout", 400);
    n_checks++; if (fail !== 1'b1 || fail_code !== 2'd1 || start_cnt - s0 != 4) begin
      n_errors++; $display("FAIL to_final: fail %b code %0d starts %0d want 1 1 4", fail, fail_code, start_cnt - s0); end
    stuck = 1'b0;
  endtask

  task automatic test_overflow();
    int w0;
    do_reset(); clear_knobs();
    for (int i = 0; i < 5; i++) file_mem[i] = 32'h100 + 32'(i);
    flen = 5; w0 = wr_n;
    pulse_boot();
    wait_end("ovf", 400);
    n_checks++; if (fail !== 1'b1 || fail_code !== 2'd2 || words_loaded !== 16'd4) begin
      n_errors++; $display("FAIL ovf: fail %b code %0d words %0d want 1 2 4", fail, fail_code, words_loaded); end
    n_checks++; if (wr_n - w0 != 4 || log_addr[w0+3] !== BASE + 16'd3) begin
      n_errors++; $display("FAIL ovf_writes: writes %0d last addr %h want 4 %h", wr_n - w0, log_addr[w0+3], BASE + 16'd3); end
  endtask

  task automatic test_reset_mid_write();
    int we0;
    bit seen;
    do_reset(); clear_knobs(); load_abc();
    stall_idx = wr_n; stall_cycles = 1000;
    pulse_boot();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_we) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rmw_reach: mem_we never rose, want 1"); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0 || fs_rst !== 1'b1 || busy !== 1'b0 || words_loaded !== '0 || cpu_rst_n !== 1'b0) begin
      n_errors++; $display("FAIL rmw_abort: we %b fs_rst %b busy %b words %0d cpu %b want 0 1 0 0 0", mem_we, fs_rst, busy, words_loaded, cpu_rst_n); end
    @(negedge clk); rst = 1'b1; stall_cycles = 0;
    we0 = we_total;
    repeat (5) @(negedge clk);
    n_checks++; if (we_total != we0 || fs_rst !== 1'b0) begin
      n_errors++; $display("FAIL rmw_quiet: we cycles %0d fs_rst %b want 0 0", we_total - we0, fs_rst); end
    stall_idx = -1;
    pulse_boot();
    wait_end("rmw_reboot", 300);
    n_checks++; if (done !== 1'b1 || words_loaded !== 16'd3) begin
      n_errors++; $display("FAIL rmw_reboot: done %b words %0d want 1 3", done, words_loaded); end
  endtask

  task automatic test_exclusive();
    n_checks++; if (both_seen) begin n_errors++; $display("FAIL exclusive: done&fail or overlapping fs pulses seen, want never"); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_not_found();
    test_err_retries();
    test_timeout();
    test_overflow();
    test_reset_mid_write();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
